decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode pipeline stage that replaces the combinational decoder between fetch and execute. It splits an instruction word into opcode, register and immediate fields, plus per-instruction usage flags. It holds the result in an output register behind a valid/ready handshake. An internal register scoreboard stalls issue on read-after-write and write-after-write hazards until writeback clears the pending destination.

## Interface
- `INSTR_W`, 16, instruction word width; must satisfy `INSTR_W ≥ 4 + 3*RA_W` and `INSTR_W ≥ 4 + 2*RA_W + IMM_W`
- `RA_W`, 3, register address width; register count is `2**RA_W`
- `IMM_W`, 6, immediate width
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  drops the held output instruction; has no effect on the scoreboard
- `in_valid`  in  1  `in_instr` is valid
- `in_ready`  out  1  stage accepts `in_instr` this cycle
- `in_instr`  in  `INSTR_W`  instruction word
- `out_valid`  out  1  decoded instruction held
- `out_ready`  in  1  downstream takes the decoded instruction
- `opcode`  out  4  opcode field
- `rd`, `rs1`, `rs2`  out  `RA_W` each  register fields
- `imm`  out  `IMM_W`  immediate, zero-extended meaning (execute sign-handles)
- `writes_rd`, `uses_rs1`, `uses_rs2`, `uses_imm`, `illegal`  out  1 each  decode flags
- `wb_valid`  in  1  a register write is retiring
- `wb_rd`  in  `RA_W`  destination of the retiring write
- `sb_busy`  out  `2**RA_W`  scoreboard vector (pending writes)

## Operation
- Field positions:
  - opcode = `instr[3:0]`
  - rd = top `RA_W` bits
  - rs1 = next `RA_W` bits below rd
  - rs2 = next `RA_W` bits below rs1
  - imm = the `IMM_W` bits immediately below rs1 (overlaps rs2)
- Opcode map and flags (W = writes_rd, 1 = uses_rs1, 2 = uses_rs2, I = uses_imm):
  - ADDI `0001`, SLLI `1110`, SLRI `1000`: W, 1, I
  - ADD `0011`, SUB `1011`, AND `0101`, OR `1101`, XOR `1111`, SLL `0110`, SLR `0100`: W, 1, 2
  - NOT `0010`, LOAD `1100`: W, 1
  - STORE `1010`: 1 (address), 2 (data); no W
  - `0000`, `0111`, `1001`: illegal = 1, all other flags 0
- Every field not used by the instruction is driven 0. No output retains a value from a previous instruction.
- Illegal instructions are accepted and passed downstream with `illegal` = 1. They never touch the scoreboard.
- Hazard = `in_valid` and any of:
  - (`uses_rs1` and `sb_busy[rs1]`)
  - (`uses_rs2` and `sb_busy[rs2]`)
  - (`writes_rd` and `sb_busy[rd]`)

  All register fields are tracked, including register 0.
- `in_ready` = `!hazard && (!out_valid || out_ready)`.
- Accept = `in_valid && in_ready`. On accept, the output register loads the decoded fields and sets `out_valid`. If `writes_rd`, `sb_busy[rd]` sets.
- When `out_valid && out_ready` occurs without an accept, `out_valid` clears and the fields are held.
- `wb_valid` clears `sb_busy[wb_rd]`. If a set and a clear target the same register in the same cycle, set wins.
- `flush` clears `out_valid` and forces `in_ready` low for that cycle. The scoreboard bit of the flushed instruction stays set; the owning pipeline issues the matching writeback or resets.

## Timing
- Latency: accept at edge N gives `out_valid` from N+1. Throughput is 1 instruction per cycle with no hazards.
- The hazard check uses the registered scoreboard, with no writeback bypass. After a clear at edge N, a stalled consumer is accepted at edge N+1 at the earliest.
- Outputs are registered. `in_ready` is combinational from `in_valid`, `in_instr`, `out_ready`, `flush` and state.
- Reset values: `out_valid` = 0, all field and flag outputs = 0, `sb_busy` = 0. Reset mid-transfer discards the held instruction. Reset wins over flush, accept and writeback.
- Outputs are stable while `out_valid && !out_ready`.

## Structure
- `decode_pkg`: opcode enum (values above), `decoded_t` struct (fields and flags), `decode_fn` pure function for combinational decode, reused by disassembly and bench models.
- Sub-module `reg_scoreboard`: busy vector with set and clear ports and a three-read-port busy lookup.
- Top-level `decode_stage`: handshake, output register, flush.

## Test plan
- ADD r3,r1,r2 (`0x6503`) with out_ready=1 → next cycle: opcode 3, rd 3, rs1 1, rs2 2, imm 0, W/1/2 = 1, `sb_busy` = `0x08`.
- ADDI r2,r1,5 then ADD r4,r2,r2 back-to-back → second instruction stalls (`in_ready` = 0) until the cycle after `wb_valid`/`wb_rd` = 2; it is accepted one cycle later.
- Opcode `0111` → `illegal` = 1, all fields and other flags 0, `sb_busy` unchanged.
- out_ready held 0 for 3 cycles with in_valid=1 → outputs stable, `in_ready` = 0. On release, one instruction transfers per cycle with no loss or duplication.
- Same-cycle `wb_valid` for r5 and accept of an instruction with rd=r5 (busy previously clear) → `sb_busy[5]` = 1.
- `flush` with `out_valid` = 1 → `out_valid` = 0 next cycle, scoreboard unchanged. `rst` mid-stall → all outputs 0 and `sb_busy` = 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode encoding, decode flag bundle and the pure opcode decoder.
package decode_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ILL0  = 4'b0000,
        OP_ADDI  = 4'b0001,
        OP_NOT   = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SLR   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_ILL7  = 4'b0111,
        OP_SLRI  = 4'b1000,
        OP_ILL9  = 4'b1001,
        OP_STORE = 4'b1010,
        OP_SUB   = 4'b1011,
        OP_LOAD  = 4'b1100,
        OP_OR    = 4'b1101,
        OP_SLLI  = 4'b1110,
        OP_XOR   = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic writes_rd;
        logic uses_rs1;
        logic uses_rs2;
        logic uses_imm;
        logic illegal;
    } decoded_t;

    function automatic decoded_t decode_fn(input logic [OPCODE_W-1:0] op);
        decoded_t d;
        d = '0;
        case (opcode_e'(op))
            OP_ADDI, OP_SLLI, OP_SLRI: begin
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
                d.uses_imm  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLR: begin
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
            end
            OP_NOT, OP_LOAD: begin
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
            end
            OP_STORE: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module reg_scoreboard #(
    parameter int unsigned RA_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [RA_W-1:0]      set_addr,
    input  logic                 clr_en,
    input  logic [RA_W-1:0]      clr_addr,
    input  logic [RA_W-1:0]      rd0_addr,
    input  logic [RA_W-1:0]      rd1_addr,
    input  logic [RA_W-1:0]      rd2_addr,
    output logic                 rd0_busy,
    output logic                 rd1_busy,
    output logic                 rd2_busy,
    output logic [2**RA_W-1:0]   busy
);

    localparam int unsigned NREG = 2**RA_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy     = busy_q;
    assign rd0_busy = busy_q[rd0_addr];
    assign rd1_busy = busy_q[rd1_addr];
    assign rd2_busy = busy_q[rd2_addr];

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: field split, usage flags, valid/ready output register and
// scoreboard-based RAW/WAW issue stall.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned RA_W    = 3,
    parameter int unsigned IMM_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [RA_W-1:0]      rd,
    output logic [RA_W-1:0]      rs1,
    output logic [RA_W-1:0]      rs2,
    output logic [IMM_W-1:0]     imm,
    output logic                 writes_rd,
    output logic                 uses_rs1,
    output logic                 uses_rs2,
    output logic                 uses_imm,
    output logic                 illegal,
    input  logic                 wb_valid,
    input  logic [RA_W-1:0]      wb_rd,
    output logic [2**RA_W-1:0]   sb_busy
);

    localparam int unsigned RD_LSB  = INSTR_W - RA_W;
    localparam int unsigned RS1_LSB = INSTR_W - 2*RA_W;
    localparam int unsigned RS2_LSB = INSTR_W - 3*RA_W;
    localparam int unsigned IMM_LSB = RS1_LSB - IMM_W;

    logic [RA_W-1:0] raw_rd, raw_rs1, raw_rs2;
    logic            rd_busy, rs1_busy, rs2_busy;
    logic            hazard, accept;
    decoded_t        dec_flags;

    logic                valid_q, valid_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [RA_W-1:0]     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [IMM_W-1:0]    imm_q, imm_d;
    decoded_t            flags_q, flags_d;

    assign raw_rd    = in_instr[RD_LSB  +: RA_W];
    assign raw_rs1   = in_instr[RS1_LSB +: RA_W];
    assign raw_rs2   = in_instr[RS2_LSB +: RA_W];
    assign dec_flags = decode_fn(in_instr[OPCODE_W-1:0]);

    reg_scoreboard #(.RA_W(RA_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && dec_flags.writes_rd),
        .set_addr (raw_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .rd0_addr (raw_rd),
        .rd1_addr (raw_rs1),
        .rd2_addr (raw_rs2),
        .rd0_busy (rd_busy),
        .rd1_busy (rs1_busy),
        .rd2_busy (rs2_busy),
        .busy     (sb_busy)
    );

    assign hazard   = in_valid && ((dec_flags.uses_rs1  && rs1_busy) ||
                                   (dec_flags.uses_rs2  && rs2_busy) ||
                                   (dec_flags.writes_rd && rd_busy));
    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Unused fields load as zero so nothing leaks from an earlier instruction.
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        flags_d  = flags_q;
        if (accept) begin
            valid_d  = 1'b1;
            opcode_d = dec_flags.illegal   ? '0 : in_instr[OPCODE_W-1:0];
            rd_d     = dec_flags.writes_rd ? raw_rd  : '0;
            rs1_d    = dec_flags.uses_rs1  ? raw_rs1 : '0;
            rs2_d    = dec_flags.uses_rs2  ? raw_rs2 : '0;
            imm_d    = dec_flags.uses_imm  ? in_instr[IMM_LSB +: IMM_W] : '0;
            flags_d  = dec_flags;
        end else if (flush || out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign imm       = imm_q;
    assign writes_rd = flags_q.writes_rd;
    assign uses_rs1  = flags_q.uses_rs1;
    assign uses_rs2  = flags_q.uses_rs2;
    assign uses_imm  = flags_q.uses_imm;
    assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, wb_valid;
    logic        in_ready, out_valid;
    logic [15:0] in_instr;
    logic [2:0]  wb_rd;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs1, rs2;
    logic [5:0]  imm;
    logic        writes_rd, uses_rs1, uses_rs2, uses_imm, illegal;
    logic [7:0]  sb_busy;

    int errors = 0;
    int checks = 0;

    // Model state: held output (packed as opcode,rd,rs1,rs2,imm,W,1,2,I,ill) and busy registers.
    logic        m_valid = 1'b0;
    logic [23:0] m_out   = '0;
    logic [7:0]  m_busy  = '0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .writes_rd(writes_rd), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .uses_imm(uses_imm), .illegal(illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .sb_busy(sb_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction classes from the opcode map, then fields by arithmetic shift/mask.
    function automatic logic [23:0] ref_decode(input logic [15:0] ins);
        int op, cls;
        logic w, u1, u2, ui, ill;
        int f_rd, f_rs1, f_rs2, f_imm, f_op;
        op = int'(ins & 16'hF);
        if (op == 1 || op == 14 || op == 8)                       cls = 1;
        else if (op == 3 || op == 11 || op == 5 || op == 13 ||
                 op == 15 || op == 6 || op == 4)                  cls = 2;
        else if (op == 2 || op == 12)                             cls = 3;
        else if (op == 10)                                        cls = 4;
        else                                                      cls = 0;
        ill = (cls == 0);
        w   = (cls == 1 || cls == 2 || cls == 3);
        u1  = !ill;
        u2  = (cls == 2 || cls == 4);
        ui  = (cls == 1);
        f_op  = ill ? 0 : op;
        f_rd  = w  ? int'((ins >> 13) & 16'h7)  : 0;
        f_rs1 = u1 ? int'((ins >> 10) & 16'h7)  : 0;
        f_rs2 = u2 ? int'((ins >> 7)  & 16'h7)  : 0;
        f_imm = ui ? int'((ins >> 4)  & 16'h3F) : 0;
        return {4'(f_op), 3'(f_rd), 3'(f_rs1), 3'(f_rs2), 6'(f_imm), w, u1, u2, ui, ill};
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        logic [23:0] dec;
        logic        haz, rdy, acc, n_valid;
        logic [23:0] n_out;
        logic [7:0]  n_busy;
        #1;
        dec = ref_decode(in_instr);
        haz = in_valid && ((dec[3] && m_busy[in_instr[12:10]]) ||
                           (dec[2] && m_busy[in_instr[9:7]])   ||
                           (dec[4] && m_busy[in_instr[15:13]]));
        rdy = !flush && !haz && (!m_valid || out_ready);
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc     = in_valid && rdy;
        n_valid = m_valid;
        n_out   = m_out;
        n_busy  = m_busy;
        if (acc) begin
            n_valid = 1'b1;
            n_out   = dec;
        end else if (flush || out_ready) begin
            n_valid = 1'b0;
        end
        if (wb_valid) n_busy[wb_rd] = 1'b0;
        if (acc && dec[4]) n_busy[in_instr[15:13]] = 1'b1;
        if (rst) begin
            n_valid = 1'b0;
            n_out   = '0;
            n_busy  = '0;
        end
        @(posedge clk);
        m_valid = n_valid;
        m_out   = n_out;
        m_busy  = n_busy;
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("fields", 32'({opcode, rd, rs1, rs2, imm, writes_rd, uses_rs1, uses_rs2, uses_imm, illegal}),
              32'(m_out));
        check("sb_busy", 32'(sb_busy), 32'(m_busy));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  busy_snap;
        logic [23:0] out_snap;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        check("reset_busy", 32'(sb_busy), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);

        // ADD r3,r1,r2
        in_valid = 1'b1; in_instr = 16'h6503;
        step();
        in_valid = 1'b0;
        check("add_fields", 32'({opcode, rd, rs1, rs2, imm}), 32'({4'd3, 3'd3, 3'd1, 3'd2, 6'd0}));
        check("add_busy", 32'(sb_busy), 32'h08);
        step();
        wb_valid = 1'b1; wb_rd = 3'd3;
        step();
        wb_valid = 1'b0;

        // ADDI r2,r1,5 then dependent ADD r4,r2,r2
        in_valid = 1'b1; in_instr = 16'h4451;
        step();
        check("addi_imm", 32'(imm), 32'd5);
        in_instr = 16'h8903;
        step();
        check("raw_stall", 32'(in_ready), 32'h0);
        step();
        wb_valid = 1'b1; wb_rd = 3'd2;
        step();
        wb_valid = 1'b0;
        #1 check("stall_release", 32'(in_ready), 32'h1);
        step();
        check("dep_accept_rd", 32'(rd), 32'd4);
        in_valid = 1'b0;
        step();

        // Illegal opcode 0111
        busy_snap = sb_busy;
        in_valid = 1'b1; in_instr = 16'hFFF7;
        step();
        in_valid = 1'b0;
        check("illegal_out", 32'({opcode, rd, rs1, rs2, imm, writes_rd, uses_rs1, uses_rs2, uses_imm, illegal}),
              32'h1);
        check("illegal_busy", 32'(sb_busy), 32'(busy_snap));
        wb_valid = 1'b1; wb_rd = 3'd4;
        step();
        wb_valid = 1'b0;

        // Backpressure: three cycles stalled, then drain
        in_valid = 1'b1; in_instr = 16'hA083;
        step();
        out_snap = {opcode, rd, rs1, rs2, imm, writes_rd, uses_rs1, uses_rs2, uses_imm, illegal};
        out_ready = 1'b0; in_instr = 16'hC083;
        for (int i = 0; i < 3; i++) step();
        check("bp_stable", 32'({opcode, rd, rs1, rs2, imm, writes_rd, uses_rs1, uses_rs2, uses_imm, illegal}),
              32'(out_snap));
        out_ready = 1'b1;
        step();
        check("bp_next_rd", 32'(rd), 32'd6);
        in_instr = 16'hE083;
        step();
        in_valid = 1'b0;
        step();
        for (int r = 5; r < 8; r++) begin
            wb_valid = 1'b1; wb_rd = 3'(r);
            step();
        end
        wb_valid = 1'b0;
        check("bp_cleared", 32'(sb_busy), 32'h0);

        // Same-cycle writeback and issue on r5: set wins
        in_valid = 1'b1; in_instr = 16'hA083; wb_valid = 1'b1; wb_rd = 3'd5;
        step();
        in_valid = 1'b0; wb_valid = 1'b0;
        check("set_wins", 32'(sb_busy[5]), 32'h1);

        // Flush drops output, keeps scoreboard
        in_valid = 1'b1; in_instr = 16'h0083;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_busy", 32'(sb_busy), 32'h21);

        // Reset during a stall
        in_valid = 1'b1; in_instr = 16'hA083;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_outs", 32'({out_valid, opcode, rd, rs1, rs2, imm, writes_rd, uses_rs1, uses_rs2, uses_imm, illegal}),
              32'h0);
        check("rst_busy", 32'(sb_busy), 32'h0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = 16'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = 3'($urandom());
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
